ib_square_iter: RTL and testbench

Parametrised multi-cycle squarer with a valid/ready handshake on input and output. It replaces the fixed 8-bit combinational squarer where a single-cycle 2·WIDTH-bit product would limit Fmax on iCE40 fabric. It consumes BPC operand bits per clock and produces the exact square of an unsigned WIDTH-bit operand after WIDTH/BPC cycles. It sits as a benchmark datapath unit in the ib_square family.

---
 rtl/ib_square_iter.sv | 122 ++++++++++++
 tb/tb_ib_square_iter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ib_square_iter.sv
// ib_square_iter: multi-cycle unsigned squarer with valid/ready handshakes.
// Each RUN cycle multiplies the captured operand by one BPC-bit chunk of itself
// (LSB chunk first) and adds the shifted partial product into the accumulator,
// so the exact square is ready after N = WIDTH/BPC cycles.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_valid  operand present on i_a
//   o_ready  block can accept an operand this cycle (IDLE and not in reset)
//   i_a      WIDTH-bit unsigned operand, sampled on acceptance only
//   o_valid  result present on o_c (DONE state)
//   i_ready  downstream accepts the result this cycle
//   o_c      2*WIDTH-bit result, i_a*i_a; holds until the next result
module ib_square_iter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_a,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_c
);

  localparam int unsigned N  = WIDTH / BPC;
  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  // Reject parameter sets that cannot be split into whole chunks.
  if ((WIDTH < 2) || ((WIDTH % BPC) != 0)) begin : g_bad_param
    $error("ib_square_iter: WIDTH must be >= 2 and a multiple of BPC");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q,   state_d;
  logic [WIDTH-1:0]  operand_q, operand_d;
  logic [AW-1:0]     acc_q,     acc_d;
  logic [CW-1:0]     step_q,    step_d;
  logic [AW-1:0]     result_q,  result_d;

  int unsigned       shamt_c;
  logic [BPC-1:0]    chunk_c;
  logic [AW-1:0]     partial_c;
  logic [AW-1:0]     acc_sum_c;

  // Partial product of the operand with the current chunk, aligned to its weight.
  always_comb begin
    shamt_c   = 32'(step_q) * BPC;
    chunk_c   = BPC'(operand_q >> shamt_c);
    partial_c = (AW'(operand_q) * AW'(chunk_c)) << shamt_c;
    acc_sum_c = acc_q + partial_c;
  end

  // Next-state, datapath update and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    step_d    = step_q;
    result_d  = result_q;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = !i_rst;
        if (i_valid) begin
          state_d   = RUN;
          operand_d = i_a;
          acc_d     = '0;
          step_d    = '0;
        end
      end
      RUN: begin
        acc_d  = acc_sum_c;
        step_d = step_q + CW'(1);
        if (step_q == LAST_STEP) begin
          state_d  = DONE;
          result_d = acc_sum_c;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides any handshake in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      operand_q <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      result_q  <= result_d;
    end
  end

  assign o_c = result_q;

endmodule

// File: tb/tb_ib_square_iter.sv
// Testbench for ib_square_iter: three instances (8/1, 8/4, 16/2) checked
// against a plain-arithmetic square model with cycle-exact latency.
module tb_ib_square_iter;

  logic        clk;
  logic        rst;

  logic        v8, rdy8, ov8, ir8;
  logic [7:0]  a8;
  logic [15:0] c8;

  logic        v4, rdy4, ov4, ir4;
  logic [7:0]  a4;
  logic [15:0] c4;

  logic        v16, rdy16, ov16, ir16;
  logic [15:0] a16;
  logic [31:0] c16;

  int unsigned n_pass;
  int unsigned n_total;
  int unsigned n_fail;

  ib_square_iter #(.WIDTH(8), .BPC(1)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8), .i_a(a8),
    .o_valid(ov8), .i_ready(ir8), .o_c(c8)
  );

  ib_square_iter #(.WIDTH(8), .BPC(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(rdy4), .i_a(a4),
    .o_valid(ov4), .i_ready(ir4), .o_c(c4)
  );

  ib_square_iter #(.WIDTH(16), .BPC(2)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(rdy16), .i_a(a16),
    .o_valid(ov16), .i_ready(ir16), .o_c(c16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One operation on the 8/1 instance: exact latency of 8 edges, optional
  // DONE stall, optional i_valid held high with junk operands after acceptance.
  task automatic op8(input logic [7:0] a, input bit hold_valid, input int unsigned stall);
    logic [15:0] e;
    e = 16'(32'(a) * 32'(a));
    ir8 = (stall == 0);
    check("op8 idle o_ready", 64'(rdy8), 64'd1);
    a8 = a;
    v8 = 1'b1;
    tick();
    v8 = hold_valid;
    a8 = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      check("op8 run o_valid", 64'(ov8), 64'd0);
      check("op8 run o_ready", 64'(rdy8), 64'd0);
      tick();
      a8 = 8'($urandom);
    end
    check("op8 done o_valid", 64'(ov8), 64'd1);
    check("op8 result", 64'(c8), 64'(e));
    check("op8 done o_ready", 64'(rdy8), 64'd0);
    for (int s = 0; s < int'(stall); s++) begin
      tick();
      check("op8 stall o_valid", 64'(ov8), 64'd1);
      check("op8 stall result", 64'(c8), 64'(e));
      check("op8 stall o_ready", 64'(rdy8), 64'd0);
    end
    ir8 = 1'b1;
    tick();
    v8 = 1'b0;
    check("op8 after o_valid", 64'(ov8), 64'd0);
    check("op8 after o_ready", 64'(rdy8), 64'd1);
    check("op8 result held", 64'(c8), 64'(e));
  endtask

  task automatic op4(input logic [7:0] a);
    logic [15:0] e;
    e = 16'(32'(a) * 32'(a));
    check("op4 idle o_ready", 64'(rdy4), 64'd1);
    a4 = a;
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    a4 = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      check("op4 run o_valid", 64'(ov4), 64'd0);
      tick();
    end
    check("op4 done o_valid", 64'(ov4), 64'd1);
    check("op4 result", 64'(c4), 64'(e));
    tick();
    check("op4 after o_ready", 64'(rdy4), 64'd1);
  endtask

  task automatic op16(input logic [15:0] a);
    logic [31:0] e;
    e = 32'(a) * 32'(a);
    check("op16 idle o_ready", 64'(rdy16), 64'd1);
    a16 = a;
    v16 = 1'b1;
    tick();
    v16 = 1'b0;
    a16 = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      check("op16 run o_valid", 64'(ov16), 64'd0);
      tick();
    end
    check("op16 done o_valid", 64'(ov16), 64'd1);
    check("op16 result", 64'(c16), 64'(e));
    tick();
    check("op16 after o_ready", 64'(rdy16), 64'd1);
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    rst = 1'b1;
    v8 = 1'b0;  ir8 = 1'b1;  a8 = '0;
    v4 = 1'b0;  ir4 = 1'b1;  a4 = '0;
    v16 = 1'b0; ir16 = 1'b1; a16 = '0;

    // Reset state
    tick();
    tick();
    check("reset o_ready", 64'(rdy8), 64'd0);
    check("reset o_valid", 64'(ov8), 64'd0);
    check("reset o_c", 64'(c8), 64'd0);
    rst = 1'b0;
    #1;
    check("post-reset o_ready", 64'(rdy8), 64'd1);

    // Corner operands
    op8(8'hFF, 1'b0, 0);
    op8(8'h00, 1'b0, 0);

    // Full sweep, i_valid held high with junk operands during RUN/DONE
    for (int i = 0; i < 256; i++) begin
      op8(8'(i), 1'b1, 0);
    end

    // Backpressure in DONE
    op8(8'h0D, 1'b0, 5);

    // Reset in the middle of RUN
    a8 = 8'hAA;
    v8 = 1'b1;
    tick();
    v8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid-run rst o_ready", 64'(rdy8), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid-run rst o_valid", 64'(ov8), 64'd0);
    check("mid-run rst o_c", 64'(c8), 64'd0);
    check("mid-run rst o_ready", 64'(rdy8), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mid-run rst no pulse", 64'(ov8), 64'd0);
    end
    op8(8'h03, 1'b0, 0);

    // Reset coinciding with a handshake: nothing is accepted
    a8 = 8'h55;
    v8 = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    v8 = 1'b0;
    #1;
    check("rst+hs o_ready", 64'(rdy8), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("rst+hs no pulse", 64'(ov8), 64'd0);
      tick();
    end

    // Wider chunking configurations
    op4(8'h80);
    op4(8'hFF);
    for (int i = 0; i < 8; i++) op4(8'($urandom));
    op16(16'hFFFF);
    op16(16'h0000);
    for (int i = 0; i < 8; i++) op16(16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
